// File: rtl/eth_hdr_extract.sv
// Ingress header extractor: collects the 12-byte Ethernet MAC header from one port's
// byte stream and presents a single-entry lookup/learn request to the MAC table.
module eth_hdr_extract #(
  parameter int          ADDR_WIDTH = 48,       // only 48 is meaningful: header is fixed at 12 bytes
  parameter logic [3:0]  PORT_ID    = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  lkp_valid,
  input  logic                  lkp_ready,
  output logic [ADDR_WIDTH-1:0] lkp_dst,
  output logic [ADDR_WIDTH-1:0] lkp_src,
  output logic [3:0]            lkp_port,
  output logic                  lkp_learn,
  output logic                  lkp_bcast,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           runt_cnt,
  output logic                  dbg_state,
  output logic [3:0]            dbg_byte_cnt
);

  // Handshakes: a transfer happens on a rising clk edge when valid && ready are both
  // high; valid never waits on ready, and a pending request's data holds while !ready.

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [87:0] hdr_q;
  logic [95:0] hdr_full;
  logic [47:0] new_dst, new_src;
  logic        accept, hdr_done, runt, slot_busy, last_hdr_byte;

  assign slot_busy     = lkp_valid && !lkp_ready;
  assign last_hdr_byte = (state_q == HDR) && (byte_cnt_q == 4'd11);
  // Combinational from lkp_ready so a draining slot can be reloaded without a bubble.
  assign in_ready      = !(last_hdr_byte && slot_busy);
  assign accept        = in_valid && in_ready;

  // Byte 0 is the oldest in the shift register, so it lands in the top bits.
  assign hdr_full = {hdr_q, in_data};
  assign new_dst  = hdr_full[95:48];
  assign new_src  = hdr_full[47:0];

  assign lkp_port     = PORT_ID;
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_done   = 1'b0;
    runt       = 1'b0;
    if (accept) begin
      case (state_q)
        HDR: begin
          if (byte_cnt_q == 4'd11) begin
            hdr_done   = 1'b1;
            byte_cnt_d = 4'd0;
            state_d    = in_last ? HDR : BODY;
          end else if (in_last) begin
            runt       = 1'b1;
            byte_cnt_d = 4'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
        BODY: begin
          if (in_last) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR;
      byte_cnt_q <= 4'd0;
      hdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      if (accept && state_q == HDR) hdr_q <= {hdr_q[79:0], in_data};
    end
  end

  // Output slot: a reload only happens when the slot is empty or draining this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lkp_valid <= 1'b0;
      lkp_dst   <= '0;
      lkp_src   <= '0;
      lkp_learn <= 1'b0;
      lkp_bcast <= 1'b0;
    end else if (hdr_done) begin
      lkp_valid <= 1'b1;
      lkp_dst   <= new_dst;
      lkp_src   <= new_src;
      // All-zero is the table's empty marker; group addresses are never learned.
      lkp_learn <= (new_src != 48'd0) && !new_src[40];
      lkp_bcast <= (new_dst == {48{1'b1}});
    end else if (lkp_ready) begin
      lkp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 16'd0;
      runt_cnt  <= 16'd0;
    end else begin
      if (hdr_done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (runt && runt_cnt != 16'hFFFF)      runt_cnt  <= runt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_hdr_extract.sv
// Self-checking bench for eth_hdr_extract: scenario tasks plus a request scoreboard.
module tb_eth_hdr_extract;

  localparam logic [3:0] PORT = 4'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        lkp_valid;
  logic        lkp_ready = 1'b1;
  logic [47:0] lkp_dst, lkp_src;
  logic [3:0]  lkp_port;
  logic        lkp_learn, lkp_bcast;
  logic [15:0] frame_cnt, runt_cnt;
  logic        dbg_state;
  logic [3:0]  dbg_byte_cnt;

  int checks = 0;
  int failures = 0;
  int vld_cycles = 0;
  logic [97:0] exp_q[$];
  logic [97:0] obs_q[$];

  eth_hdr_extract #(.ADDR_WIDTH(48), .PORT_ID(PORT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
    .lkp_dst(lkp_dst), .lkp_src(lkp_src), .lkp_port(lkp_port),
    .lkp_learn(lkp_learn), .lkp_bcast(lkp_bcast),
    .frame_cnt(frame_cnt), .runt_cnt(runt_cnt),
    .dbg_state(dbg_state), .dbg_byte_cnt(dbg_byte_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: record every delivered request and every cycle lkp_valid is high.
  always @(negedge clk) begin
    if (!reset) begin
      if (lkp_valid) vld_cycles <= vld_cycles + 1;
      if (lkp_valid && lkp_ready) obs_q.push_back({lkp_dst, lkp_src, lkp_learn, lkp_bcast});
    end
  end

  function automatic logic [97:0] model(input logic [47:0] d, input logic [47:0] s);
    logic learn, bcast;
    learn = (s != 48'd0) && (s[40] == 1'b0);
    bcast = (d == 48'hFFFF_FFFF_FFFF);
    return {d, s, learn, bcast};
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    logic ok;
    in_valid = 1'b1; in_data = d; in_last = last; n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1; else n++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=0 exp=1 after %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input int len, input int gap_max);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      if (k < 6)       b = d[47-8*k -: 8];
      else if (k < 12) b = s[47-8*(k-6) -: 8];
      else             b = 8'($urandom_range(0, 255));
      if (k == 11) exp_q.push_back(model(d, s));
      send_byte(b, k == len - 1);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
    end
  endtask

  // Compare delivered requests against expected, in order, then empty both queues.
  task automatic drain_sb(input string name);
    logic [97:0] o, e;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_req_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s_req got=%h exp=%h", name, o, e);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (lkp_valid !== 1'b0) begin failures++; $display("FAIL reset_lkp_valid got=%b exp=0", lkp_valid); end
    checks++;
    if ({lkp_learn, lkp_bcast, lkp_port, frame_cnt, runt_cnt, lkp_dst, lkp_src} !== {2'b00, PORT, 32'd0, 96'd0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {lkp_learn, lkp_bcast, lkp_port, frame_cnt, runt_cnt, lkp_dst, lkp_src}, {2'b00, PORT, 32'd0, 96'd0});
    end
  endtask

  task automatic test_basic();
    logic [47:0] d, s;
    int v0;
    do_reset();
    lkp_ready = 1'b1;
    d = 48'h0011_2233_4455; s = 48'h6677_8899_AABB;
    v0 = vld_cycles;
    for (int k = 0; k < 64; k++) begin
      if (k < 6)       in_data = d[47-8*k -: 8];
      else if (k < 12) in_data = s[47-8*(k-6) -: 8];
      else             in_data = 8'($urandom_range(0, 255));
      if (k == 11) exp_q.push_back(model(d, s));
      send_byte(in_data, k == 63);
      if (k == 10) begin
        checks++;
        if (lkp_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", lkp_valid); end
      end
      if (k == 11) begin
        @(negedge clk);
        checks++;
        if (lkp_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", lkp_valid); end
      end
    end
    drain_sb("basic");
    checks++;
    if (vld_cycles - v0 != 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", vld_cycles - v0); end
    checks++;
    if ({lkp_dst, lkp_src, lkp_learn, lkp_bcast} !== {48'h001122334455, 48'h66778899AABB, 2'b10}) begin
      failures++; $display("FAIL basic_fields got=%h/%h/%b%b", lkp_dst, lkp_src, lkp_learn, lkp_bcast);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_runt();
    int v0;
    do_reset();
    lkp_ready = 1'b1;
    v0 = vld_cycles;
    send_frame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 8, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vld_cycles != v0) begin failures++; $display("FAIL runt_valid got=%0d exp=0 cycles", vld_cycles - v0); end
    checks++;
    if (runt_cnt !== 16'd1) begin failures++; $display("FAIL runt_cnt got=%0d exp=1", runt_cnt); end
    send_frame(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 64, 1);
    drain_sb("runt_next");
    checks++;
    if ({frame_cnt, runt_cnt} !== {16'd1, 16'd1}) begin
      failures++; $display("FAIL runt_counts got=%0d/%0d exp=1/1", frame_cnt, runt_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] d1, s1, d2, s2;
    do_reset();
    lkp_ready = 1'b0;
    d1 = 48'h1111_2222_3333; s1 = 48'h0244_5566_7788;
    d2 = 48'h9999_AAAA_BBBB; s2 = 48'h00CC_DDEE_FF01;
    fork
      begin
        send_frame(d1, s1, 12, 0);
        send_frame(d2, s2, 12, 0);
      end
      begin
        repeat (29) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++;
        if ({lkp_valid, lkp_dst, lkp_src} !== {1'b1, d1, s1}) begin
          failures++; $display("FAIL bp_hold got=%b/%h/%h exp=1/%h/%h", lkp_valid, lkp_dst, lkp_src, d1, s1);
        end
        checks++;
        if (dbg_byte_cnt !== 4'd11) begin failures++; $display("FAIL bp_byte_cnt got=%0d exp=11", dbg_byte_cnt); end
      end
      begin
        repeat (30) @(posedge clk);
        #1 lkp_ready = 1'b1;
      end
    join
    drain_sb("bp");
    checks++;
    if (frame_cnt !== 16'd2) begin failures++; $display("FAIL bp_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_qualifiers();
    do_reset();
    lkp_ready = 1'b1;
    send_frame(48'hFFFF_FFFF_FFFF, 48'h0, 20, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lkp_bcast, lkp_learn} !== 2'b10) begin
      failures++; $display("FAIL qual_bcast_zero got=%b%b exp=10", lkp_bcast, lkp_learn);
    end
    send_frame(48'h0011_2233_4455, 48'h0100_5E00_0001, 14, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lkp_bcast, lkp_learn} !== 2'b00) begin
      failures++; $display("FAIL qual_group_src got=%b%b exp=00", lkp_bcast, lkp_learn);
    end
    send_frame(48'hFFFF_FFFF_FFFE, 48'h0000_0000_0001, 12, 0);
    drain_sb("qual");
  endtask

  task automatic test_reset_mid();
    do_reset();
    lkp_ready = 1'b0;
    send_frame(48'h5555_6666_7777, 48'h0000_1111_2222, 12, 0);
    send_frame(48'hDEAD_BEEF_0001, 48'h0, 6, 0);
    reset = 1'b1;
    #2;
    checks++;
    if ({in_ready, lkp_valid, lkp_learn, lkp_bcast, lkp_port, frame_cnt, runt_cnt, lkp_dst, lkp_src}
        !== {4'b1000, PORT, 32'd0, 96'd0}) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b%b %h %h", in_ready, lkp_valid, lkp_dst, lkp_src);
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    lkp_ready = 1'b1;
    send_frame(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 30, 0);
    drain_sb("reset_mid");
    checks++;
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL reset_mid_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    lkp_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_data = 8'h42;
    repeat (65536) @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (runt_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_runt_cnt got=%h exp=ffff", runt_cnt); end
    send_byte(8'h01, 1'b1);
    checks++;
    if ({runt_cnt, frame_cnt} !== {16'hFFFF, 16'd0}) begin
      failures++; $display("FAIL sat_hold got=%h/%h exp=ffff/0000", runt_cnt, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n_frames, n_runts, len;
    logic done;
    do_reset();
    n_frames = 0; n_runts = 0; done = 1'b0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          len = $urandom_range(1, 40);
          if (len >= 12) n_frames++; else n_runts++;
          send_frame({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, len, (f % 3 == 0) ? 2 : 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 lkp_ready = 1'($urandom_range(0, 1));
        end
        lkp_ready = 1'b1;
      end
    join
    drain_sb("b2b");
    checks++;
    if ({frame_cnt, runt_cnt} !== {16'(n_frames), 16'(n_runts)}) begin
      failures++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", frame_cnt, runt_cnt, n_frames, n_runts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runt();
    test_backpressure();
    test_qualifiers();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
